vga_pattern_sequencer: RTL
==========================

Name: vga_pattern_sequencer

Overview:
- Frame-synchronous controller for the VGA test-pattern chain: vga_sync_pulses → pattern_gen → vga_sync_porch.
- Watches the vsync produced by vga_sync_pulses and counts frames.
- Drives the pattern select into pattern_gen. Patterns advance automatically every FRAMES_PER_PATTERN frames, or manually on next/prev request pulses.
- Every pattern change is applied only at a frame boundary, so no frame ever shows two patterns.

Parameters:
- NUM_PATTERNS, 8: number of selectable patterns (≥2); valid indices 0..NUM_PATTERNS-1.
- SEL_WIDTH, 3: width of pattern_sel; must satisfy 2**SEL_WIDTH ≥ NUM_PATTERNS.
- FRAMES_PER_PATTERN, 120: frames each pattern is shown in auto mode (≥1).
- CNT_WIDTH, 8: width of frame_count; must hold FRAMES_PER_PATTERN-1.

Ports:
- clock  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  vsync from vga_sync_pulses, same clock domain; high during active rows.
- auto_en  in  1  level; 1 = auto-advance, 0 = hold current pattern.
- next_req  in  1  single-cycle pulse; request next pattern.
- prev_req  in  1  single-cycle pulse; request previous pattern.
- pattern_sel  out  SEL_WIDTH  pattern index to pattern_gen.
- frame_end  out  1  one-cycle pulse per frame boundary.
- switch_pulse  out  1  one-cycle pulse when pattern_sel changes.
- frame_count  out  CNT_WIDTH  frames shown of the current pattern.
- blank  out  1  force-black request to pattern_gen (see Optional Feature).

Behaviour:
- Reset (async assert, synchronous release): pattern_sel=0, frame_count=0, frame_end=0, switch_pulse=0, blank=0; vsync_q=0; pending requests cleared; state=SYNC.
- Frame boundary = vsync falling edge. vsync_q is a registered copy of vsync. Boundary condition: vsync_q=1 and vsync=0 in cycle N.
- frame_end is registered high in cycle N+1 for exactly 1 cycle.
- pattern_sel, frame_count and switch_pulse update on the same edge as frame_end (latency 1 cycle from the edge).
- Request latching, every cycle and in every state:
  - next_req sets pend_next; prev_req sets pend_prev.
  - Both pulsing in the same cycle, or both pending at the boundary: they cancel, no change.
  - Pendings clear at each boundary; they are held through multiple request pulses (no queueing, at most one step per frame).
  - A request arriving in the same cycle N as the boundary is honoured at that boundary.
- State machine, transitions only on a boundary:
  - SYNC: waits for the first boundary after reset; pattern_sel held at 0. At that boundary it goes to RUN if auto_en=1, else HOLD, without advancing the pattern. Requests pending at this boundary are discarded.
  - RUN: at each boundary, auto_en=0 → HOLD; otherwise RUN.
  - HOLD: at each boundary, auto_en=1 → RUN; otherwise HOLD.
  - auto_en is sampled only at boundaries; changes between boundaries have no effect.
- At a boundary in RUN/HOLD, in priority order:
  1. Net manual request (next xor prev): step pattern_sel, set frame_count=0, pulse switch_pulse.
  2. Else RUN with frame_count==FRAMES_PER_PATTERN-1: pattern_sel+1, frame_count=0, pulse switch_pulse.
  3. Else RUN: frame_count+1.
  4. Else HOLD: frame_count frozen.
- Simultaneous manual next and auto expiry advance exactly one step, not two.
- Wrap: next from NUM_PATTERNS-1 → 0; prev from 0 → NUM_PATTERNS-1. Values ≥ NUM_PATTERNS never appear.
- Reset asserted mid-frame forces the reset values immediately, and the block resynchronises via SYNC.

Optional Feature:
- Macro: VGA_PATTERN_SEQ_BLANK_EN.
- Enabled: on every switch, blank goes high with switch_pulse and stays high for exactly one full frame, deasserting at the next frame_end. A further switch during blanking restarts the one-frame window. frame_count does not increment during a blank frame.
- Disabled: blank is tied to 0 and there is no added logic.

Test Plan (NUM_PATTERNS=3, FRAMES_PER_PATTERN=3, macro off unless stated):
1. Reset, auto_en=1, 10 frames of vsync → first boundary enters RUN with sel=0. Then frame_count 1,2, and at the 3rd frame sel=1 with switch_pulse. sel=2 after 3 more frames; sel wraps to 0 after 3 more.
2. auto_en=0 after SYNC, next_req pulsed twice mid-frame → one step per boundary only: sel 0→1 at the next frame_end. Then prev_req → sel 1→0. frame_count stays 0 throughout.
3. HOLD, sel=0, prev_req → sel=2. Then next_req and prev_req in the same cycle → no change and no switch_pulse.
4. RUN with frame_count=2 plus next_req in the same frame → sel advances by exactly 1 and frame_count=0.
5. reset_n driven low mid-frame with sel=2 → outputs are reset values in the same cycle. After release, the first boundary gives SYNC→RUN and sel stays 0.
6. Macro on, auto switch → blank=1 from switch_pulse until the following frame_end (one frame), then 0. frame_count is 0 during the blank frame.

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-synchronous pattern select for the VGA test chain.
// Build macro VGA_PATTERN_SEQ_BLANK_EN adds a one-frame blank after each switch.
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS       = 8,
  parameter int SEL_WIDTH          = 3,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 auto_en,
  input  logic                 next_req,
  input  logic                 prev_req,
  output logic [SEL_WIDTH-1:0] pattern_sel,
  output logic                 frame_end,
  output logic                 switch_pulse,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 blank
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [SEL_WIDTH-1:0] SEL_MAX =
    SEL_WIDTH'(NUM_PATTERNS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(FRAMES_PER_PATTERN - 1);

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic                 pend_next_q, pend_next_d;
  logic                 pend_prev_q, pend_prev_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 fe_q, fe_d;
  logic                 sw_q, sw_d;

  logic                 boundary;
  logic                 req_next;
  logic                 req_prev;
  logic [SEL_WIDTH-1:0] sel_inc;
  logic [SEL_WIDTH-1:0] sel_dec;
  logic                 cnt_frozen;

  assign boundary = vsync_q & ~vsync;

  // requests landing in the boundary cycle still count
  assign req_next = pend_next_q | next_req;
  assign req_prev = pend_prev_q | prev_req;

  assign sel_inc = (sel_q == SEL_MAX) ?
    '0 : sel_q + SEL_WIDTH'(1);
  assign sel_dec = (sel_q == '0) ?
    SEL_MAX : sel_q - SEL_WIDTH'(1);

  assign pattern_sel  = sel_q;
  assign frame_count  = cnt_q;
  assign frame_end    = fe_q;
  assign switch_pulse = sw_q;

`ifdef VGA_PATTERN_SEQ_BLANK_EN
  logic blank_q, blank_d;

  assign blank      = blank_q;
  assign cnt_frozen = blank_q;

  // blank covers the frame that follows a switch
  always_comb begin
    blank_d = blank_q;
    if (boundary) begin
      blank_d = sw_d;
    end
  end

  // blank window register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  assign blank      = 1'b0;
  assign cnt_frozen = 1'b0;
`endif

  // pending requests held until the next boundary
  always_comb begin
    pend_next_d = pend_next_q | next_req;
    pend_prev_d = pend_prev_q | prev_req;
    if (boundary) begin
      pend_next_d = 1'b0;
      pend_prev_d = 1'b0;
    end
  end

  // boundary-driven state, select and frame counter update
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    fe_d    = boundary;
    sw_d    = 1'b0;
    if (boundary) begin
      unique case (state_q)
        SYNC: begin
          state_d = auto_en ? RUN : HOLD;
        end
        RUN, HOLD: begin
          state_d = auto_en ? RUN : HOLD;
          if (req_next ^ req_prev) begin
            sel_d = req_next ? sel_inc : sel_dec;
            cnt_d = '0;
            sw_d  = 1'b1;
          end else if (state_q == RUN && !cnt_frozen) begin
            if (cnt_q == CNT_MAX) begin
              sel_d = sel_inc;
              cnt_d = '0;
              sw_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      vsync_q     <= 1'b0;
      pend_next_q <= 1'b0;
      pend_prev_q <= 1'b0;
      sel_q       <= '0;
      cnt_q       <= '0;
      fe_q        <= 1'b0;
      sw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      pend_next_q <= pend_next_d;
      pend_prev_q <= pend_prev_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      fe_q        <= fe_d;
      sw_q        <= sw_d;
    end
  end

endmodule
